// File: rtl/sequential_neural_network.sv
// Time-multiplexed dense network: one MAC per clock walks every layer in turn,
// with weights and biases held in a write-port-loaded register file.
module sequential_neural_network #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRACTION_BITS = 8,
    parameter int NUM_LAYERS    = 4,
    parameter int MAX_SIZE      = 4,
    parameter int SIZES [NUM_LAYERS] = '{2, 4, 4, 2},
    // 0 selects relu, 1 selects the hard sigmoid
    parameter bit ACTIVATIONS [NUM_LAYERS-1] = '{1'b0, 1'b0, 1'b1},
    parameter int ADDRESS_WIDTH = $clog2((NUM_LAYERS-1)*MAX_SIZE*(MAX_SIZE+1))
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inputs_ready,
    input  logic signed [DATA_WIDTH-1:0] inputs [SIZES[0]],
    input  logic                         weight_write,
    input  logic [ADDRESS_WIDTH-1:0]     weight_address,
    input  logic signed [DATA_WIDTH-1:0] weight_data,
    output logic signed [DATA_WIDTH-1:0] outputs [SIZES[NUM_LAYERS-1]],
    output logic                         outputs_ready,
    output logic                         busy
);

    localparam int ACC_W         = 2*DATA_WIDTH + $clog2(MAX_SIZE) + 1;
    localparam int PROD_W        = 2*DATA_WIDTH;
    localparam int NEURON_STRIDE = MAX_SIZE + 1;
    localparam int LAYER_STRIDE  = MAX_SIZE * NEURON_STRIDE;
    localparam int MEM_DEPTH     = (NUM_LAYERS-1) * LAYER_STRIDE;
    localparam int CNT_W         = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int LAYER_W       = $clog2(NUM_LAYERS);
    localparam int IN_N          = SIZES[0];
    localparam int OUT_N         = SIZES[NUM_LAYERS-1];
    localparam int SIG_W         = DATA_WIDTH + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SIG_W-1:0] SIG_HALF = SIG_W'(1 << (FRACTION_BITS-1));
    localparam logic signed [SIG_W-1:0] SIG_ONE  = SIG_W'(1 << FRACTION_BITS);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACTIVATE, S_DONE} state_t;

    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0] weight_mem [MEM_DEPTH];
    logic signed [DATA_WIDTH-1:0] buf_a [MAX_SIZE];
    logic signed [DATA_WIDTH-1:0] buf_b [MAX_SIZE];
    logic                         sel;
    logic signed [ACC_W-1:0]      acc;
    logic [LAYER_W-1:0]           layer;
    logic [CNT_W-1:0]             neuron;
    logic [CNT_W-1:0]             index;

    logic [CNT_W-1:0]             last_index;
    logic [CNT_W-1:0]             last_neuron;
    logic                         use_sigmoid;
    logic                         final_layer;
    int                           rd_offset;
    logic [ADDRESS_WIDTH-1:0]     rd_addr;
    logic signed [DATA_WIDTH-1:0] mem_q;
    logic signed [DATA_WIDTH-1:0] operand;
    logic signed [PROD_W-1:0]     product;
    logic signed [ACC_W-1:0]      bias_ext;
    logic signed [DATA_WIDTH-1:0] act_y;

    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [ACC_W-1:0] v
    );
        if (v > SAT_MAX)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return DATA_WIDTH'(v);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] hard_sigmoid(
        input logic signed [DATA_WIDTH-1:0] r
    );
        logic signed [SIG_W-1:0] v;
        v = SIG_HALF + (SIG_W'(r) >>> 2);
        if (v < 0)
            return '0;
        else if (v > SIG_ONE)
            return DATA_WIDTH'(SIG_ONE);
        else
            return DATA_WIDTH'(v);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] activate(
        input logic signed [ACC_W-1:0] s,
        input logic                    sigmoid
    );
        logic signed [DATA_WIDTH-1:0] r;
        r = saturate(s >>> FRACTION_BITS);
        if (sigmoid)
            return hard_sigmoid(r);
        else
            return (r < 0) ? '0 : r;
    endfunction

    // Per-layer constants selected by the running layer counter
    always_comb begin
        last_index  = '0;
        last_neuron = '0;
        use_sigmoid = 1'b0;
        for (int l = 0; l < NUM_LAYERS-1; l++) begin
            if (layer == LAYER_W'(l)) begin
                last_index  = CNT_W'(SIZES[l] - 1);
                last_neuron = CNT_W'(SIZES[l+1] - 1);
                use_sigmoid = ACTIVATIONS[l];
            end
        end
    end

    assign final_layer = (layer == LAYER_W'(NUM_LAYERS-2));

    // The bias sits in the slot just past the last weight of each neuron
    always_comb begin
        rd_offset = int'(layer) * LAYER_STRIDE + int'(neuron) * NEURON_STRIDE
                  + ((state == S_ACTIVATE) ? MAX_SIZE : int'(index));
        rd_addr   = ADDRESS_WIDTH'(rd_offset);
    end

    assign mem_q    = weight_mem[rd_addr];
    assign operand  = sel ? buf_b[index] : buf_a[index];
    assign product  = PROD_W'(mem_q) * PROD_W'(operand);
    assign bias_ext = ACC_W'(mem_q) <<< FRACTION_BITS;
    assign act_y    = activate(acc + bias_ext, use_sigmoid);

    // Memory has no reset so loaded weights survive it; writes only land while idle
    always_ff @(posedge clock) begin
        if (weight_write && !busy &&
            ({1'b0, weight_address} < (ADDRESS_WIDTH+1)'(MEM_DEPTH)))
            weight_mem[weight_address] <= weight_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (inputs_ready) state_next = S_MAC;
            S_MAC:      if (index == last_index) state_next = S_ACTIVATE;
            S_ACTIVATE: state_next = (neuron == last_neuron && final_layer) ? S_DONE : S_MAC;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            layer         <= '0;
            neuron        <= '0;
            index         <= '0;
            sel           <= 1'b0;
            busy          <= 1'b0;
            outputs_ready <= 1'b0;
            for (int i = 0; i < MAX_SIZE; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
            for (int i = 0; i < OUT_N; i++)
                outputs[i] <= '0;
        end else begin
            outputs_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inputs_ready) begin
                        for (int i = 0; i < MAX_SIZE; i++)
                            buf_a[i] <= '0;
                        for (int i = 0; i < IN_N; i++)
                            buf_a[i] <= inputs[i];
                        acc    <= '0;
                        layer  <= '0;
                        neuron <= '0;
                        index  <= '0;
                        sel    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(product);
                    if (index != last_index)
                        index <= index + CNT_W'(1);
                end
                S_ACTIVATE: begin
                    if (sel)
                        buf_a[neuron] <= act_y;
                    else
                        buf_b[neuron] <= act_y;
                    acc   <= '0;
                    index <= '0;
                    if (neuron != last_neuron) begin
                        neuron <= neuron + CNT_W'(1);
                    end else if (!final_layer) begin
                        sel    <= ~sel;
                        layer  <= layer + LAYER_W'(1);
                        neuron <= '0;
                    end
                end
                S_DONE: begin
                    // The final layer wrote into whichever buffer was not the input side
                    for (int i = 0; i < OUT_N; i++)
                        outputs[i] <= sel ? buf_a[i] : buf_b[i];
                    outputs_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_neural_network.sv
// Directed bench for sequential_neural_network: table of weight setups with
// hand-computed results, plus handshake, reset and write-corner sequences.
module tb_sequential_neural_network;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int EXP_LAT = 43;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 inputs_ready = 1'b0;
    logic signed [DW-1:0] inputs [2];
    logic                 weight_write = 1'b0;
    logic [AW-1:0]        weight_address = '0;
    logic signed [DW-1:0] weight_data = '0;
    logic signed [DW-1:0] outputs [2];
    logic                 outputs_ready;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int w0;  int b0;
        int w1;  int b1;
        int w2a; int w2b; int b2;
        int in0; int in1;
        int exp0; int exp1;
    } vec_t;

    vec_t vecs [7];

    sequential_neural_network dut (
        .clock          (clock),
        .reset          (reset),
        .inputs_ready   (inputs_ready),
        .inputs         (inputs),
        .weight_write   (weight_write),
        .weight_address (weight_address),
        .weight_data    (weight_data),
        .outputs        (outputs),
        .outputs_ready  (outputs_ready),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic write_word(input int addr, input int data);
        weight_address = addr[AW-1:0];
        weight_data    = data[DW-1:0];
        weight_write   = 1'b1;
        @(posedge clock); #1;
        weight_write   = 1'b0;
    endtask

    function automatic int cfg_value(input vec_t v, input int l, input int n, input int i);
        if (i == 4) begin
            if (l == 0) return v.b0;
            if (l == 1) return v.b1;
            return (n < 2) ? v.b2 : 0;
        end
        if (l == 0) return (i < 2) ? v.w0 : 0;
        if (l == 1) return (i == 0) ? v.w1 : 0;
        if (i != 0) return 0;
        if (n == 0) return v.w2a;
        if (n == 1) return v.w2b;
        return 0;
    endfunction

    task automatic load_cfg(input vec_t v);
        for (int l = 0; l < 3; l++)
            for (int n = 0; n < 4; n++)
                for (int i = 0; i < 5; i++)
                    write_word(l*20 + n*5 + i, cfg_value(v, l, n, i));
    endtask

    // Starts an inference and returns at the cycle outputs_ready is seen.
    // pulse_cyc / wr_cyc inject a stray start or write while busy (-1 = none).
    task automatic run(input int in0, input int in1, input int pulse_cyc, input int wr_cyc,
                       output int lat, output int busy_cnt);
        inputs[0]    = in0[DW-1:0];
        inputs[1]    = in1[DW-1:0];
        inputs_ready = 1'b1;
        @(posedge clock); #1;
        inputs_ready = 1'b0;
        weight_write = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int c = 0; c <= 80; c++) begin
            if (outputs_ready) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
            inputs_ready = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                inputs[0] = 16'sd100;
                inputs[1] = 16'sd100;
            end
            weight_write = (c == wr_cyc);
            if (c == wr_cyc) begin
                weight_address = 6'd44;
                weight_data    = 16'sd1024;
            end
            @(posedge clock); #1;
        end
        inputs_ready = 1'b0;
        weight_write = 1'b0;
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        //       w0     b0     w1   b1    w2a  w2b   b2     in0    in1   exp0 exp1
        vecs[0] = '{0,     256,   0,   -256, 0,   0,    0,     5,     -7,   128, 128};
        vecs[1] = '{256,   0,     256, 0,    256, 128,  0,     512,   -256, 192, 160};
        vecs[2] = '{256,   0,     256, 0,    256, 128,  0,     -512,  0,    128, 128};
        vecs[3] = '{256,   0,     256, 0,    0,   0,    1024,  512,   -256, 256, 256};
        vecs[4] = '{256,   0,     256, 0,    0,   0,    -1024, 512,   -256, 0,   0};
        vecs[5] = '{32767, 32767, 256, 0,    1,   2,    0,     32767, 32767, 159, 191};
        vecs[6] = '{256,   -256,  512, 0,    255, -255, 0,     300,   100,  199, 56};

        inputs[0] = '0;
        inputs[1] = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_ready", outputs_ready, 0);
        check("reset_out0", outputs[0], 0);
        check("reset_out1", outputs[1], 0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < 7; k++) begin
            load_cfg(vecs[k]);
            run(vecs[k].in0, vecs[k].in1, -1, -1, lat, bcnt);
            check($sformatf("vec%0d_latency", k), lat, EXP_LAT);
            check($sformatf("vec%0d_busy_cycles", k), bcnt, EXP_LAT);
            check($sformatf("vec%0d_busy_at_ready", k), busy, 0);
            check($sformatf("vec%0d_out0", k), outputs[0], vecs[k].exp0);
            check($sformatf("vec%0d_out1", k), outputs[1], vecs[k].exp1);
            @(posedge clock); #1;
            check($sformatf("vec%0d_ready_one_cycle", k), outputs_ready, 0);
            check($sformatf("vec%0d_hold_out0", k), outputs[0], vecs[k].exp0);
        end

        // Stray start at cycle 10 and write at cycle 20 must both be ignored
        load_cfg(vecs[0]);
        run(5, -7, 10, 20, lat, bcnt);
        check("busy_events_latency", lat, EXP_LAT);
        check("busy_events_out0", outputs[0], 128);
        check("busy_events_out1", outputs[1], 128);
        // Back-to-back start; a landed write to address 44 would make out0 256
        run(5, -7, -1, -1, lat, bcnt);
        check("back_to_back_latency", lat, EXP_LAT);
        check("back_to_back_out0", outputs[0], 128);
        check("back_to_back_out1", outputs[1], 128);

        // Load distinct outputs first so the reset clearing them is visible
        run(5, -7, -1, -1, lat, bcnt);
        inputs[0] = 16'sd5;
        inputs[1] = -16'sd7;
        inputs_ready = 1'b1;
        @(posedge clock); #1;
        inputs_ready = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out0", outputs[0], 0);
        check("abort_out1", outputs[1], 0);
        check("abort_ready", outputs_ready, 0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clock); #1;
            if (outputs_ready) seen = 1;
        end
        check("abort_no_ready_pulse", seen, 0);
        run(5, -7, -1, -1, lat, bcnt);
        check("rerun_latency", lat, EXP_LAT);
        check("rerun_out0", outputs[0], 128);
        check("rerun_out1", outputs[1], 128);

        // Out-of-range writes must not disturb any stored weight
        write_word(63, 1024);
        write_word(60, 1024);
        run(5, -7, -1, -1, lat, bcnt);
        check("oob_write_out0", outputs[0], 128);
        check("oob_write_out1", outputs[1], 128);

        // Write and start in the same idle cycle: layer-2 neuron-0 bias 1024 takes effect
        weight_address = 6'd44;
        weight_data    = 16'sd1024;
        weight_write   = 1'b1;
        run(5, -7, -1, -1, lat, bcnt);
        check("collision_latency", lat, EXP_LAT);
        check("collision_out0", outputs[0], 256);
        check("collision_out1", outputs[1], 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
